// File: rtl/gpio_mirror_ctrl_if.sv
// ============================================================================
// Module      : gpio_mirror_ctrl_if
// Description : AXI4-Lite master-side bundle used by gpio_mirror_ctrl.
//               master modport faces the controller, slave modport faces the
//               GPIO register block (or its model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gpio_mirror_ctrl_if;
  // Write address channel
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  // Write data channel
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  // Write response channel
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  // Read address channel
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  // Read data channel
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awvalid, input m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid, output m_axi_bready,
    output m_axi_araddr, m_axi_arvalid, input m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awvalid, output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid, output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready
  );
endinterface

`default_nettype wire

// File: rtl/gpio_mirror_ctrl.sv
// ============================================================================
// Module      : gpio_mirror_ctrl
// Description : Periodically reads the GPIO input register (BASE_ADDR+0x00)
//               over AXI4-Lite and, whenever the low 16 bits change, writes
//               the new value XOR xor_mask to the output register
//               (BASE_ADDR+0x04).
//               Optional macro GPIO_MIRROR_IRQ_EN: when defined, change_irq
//               pulses one cycle per detected change; otherwise it is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_mirror_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned POLL_DIV  = 1000
) (
  input  wire logic          s_axi_aclk,
  input  wire logic          s_axi_aresetn,
  gpio_mirror_ctrl_if.master axi,
  input  wire logic          enable,
  input  wire logic [15:0]   xor_mask,
  output logic               busy,
  output logic               change_irq
);

  localparam int unsigned      CNT_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_DIV - 1);
  localparam logic [31:0]      IN_ADDR  = BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0]      OUT_ADDR = BASE_ADDR + 32'h0000_0004;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ADDR  = 3'd1,
    RD_DATA  = 3'd2,
    WR_REQ   = 3'd3,
    WR_RESP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      araddr_q, araddr_d;
  logic             arvalid_q, arvalid_d;
  logic             rready_q, rready_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic             awvalid_q, awvalid_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             wvalid_q, wvalid_d;
  logic             bready_q, bready_d;
  logic [15:0]      last_in_q, last_in_d;

  logic tick;
  logic change_det;
  logic aw_done;
  logic w_done;
  logic unused_bits;

  // Upper read-data bits and the write response code carry no meaning here.
  assign unused_bits = ^{axi.m_axi_rdata[31:16], axi.m_axi_bresp};

  assign tick = (cnt_q == CNT_MAX);

  // A good read whose low half differs from the last mirrored value.
  assign change_det = (state_q == RD_DATA) && axi.m_axi_rvalid &&
                      (axi.m_axi_rresp == 2'b00) &&
                      (axi.m_axi_rdata[15:0] != last_in_q);

  // A write channel is finished once its valid is low or is being accepted now.
  assign aw_done = !awvalid_q || axi.m_axi_awready;
  assign w_done  = !wvalid_q  || axi.m_axi_wready;

  // Free-running poll divider, wraps at POLL_DIV-1.
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
  end

  // Next-state and registered-output computation for the poll/mirror sequence.
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    last_in_d = last_in_q;

    case (state_q)
      IDLE: begin
        // Ticks arriving while busy or disabled are simply lost.
        if (tick && enable) begin
          araddr_d  = IN_ADDR;
          arvalid_d = 1'b1;
          state_d   = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (axi.m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi.m_axi_rvalid) begin
          rready_d = 1'b0;
          if (change_det) begin
            // Mask is captured here so later mask changes cannot disturb the write.
            last_in_d = axi.m_axi_rdata[15:0];
            awaddr_d  = OUT_ADDR;
            wdata_d   = {16'h0000, axi.m_axi_rdata[15:0] ^ xor_mask};
            wstrb_d   = 4'hF;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && axi.m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi.m_axi_bvalid) begin
          bready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State, counter and all bus-facing registers; reset drops every handshake at once.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      last_in_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      last_in_q <= last_in_d;
    end
  end

`ifdef GPIO_MIRROR_IRQ_EN
  logic change_irq_q, change_irq_d;

  // Pulse request mirrors the change detection in the read-accept cycle.
  always_comb begin
    change_irq_d = change_det;
  end

  // Registered so the pulse lands one cycle after read data acceptance.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) change_irq_q <= 1'b0;
    else                change_irq_q <= change_irq_d;
  end

  assign change_irq = change_irq_q;
`else
  assign change_irq = 1'b0;
`endif

  assign busy              = (state_q != IDLE);
  assign axi.m_axi_araddr  = araddr_q;
  assign axi.m_axi_arvalid = arvalid_q;
  assign axi.m_axi_rready  = rready_q;
  assign axi.m_axi_awaddr  = awaddr_q;
  assign axi.m_axi_awvalid = awvalid_q;
  assign axi.m_axi_wdata   = wdata_q;
  assign axi.m_axi_wstrb   = wstrb_q;
  assign axi.m_axi_wvalid  = wvalid_q;
  assign axi.m_axi_bready  = bready_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_mirror_ctrl.sv
// ============================================================================
// Module      : tb_gpio_mirror_ctrl
// Description : Self-checking bench for gpio_mirror_ctrl. Acts as the AXI
//               slave, applies a table of poll transactions, hand-written
//               corner sequences and randomized polls checked against a
//               transaction-level reference model. Honours GPIO_MIRROR_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_mirror_ctrl;

  localparam logic [31:0] BASE   = 32'h4000_1000;
  localparam int          PDIV   = 4;
  localparam int          AR_LIM = 4 * PDIV + 8;
`ifdef GPIO_MIRROR_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [15:0] mask;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic        exp_wr;
    logic [31:0] exp_wd;
  } vec_t;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [15:0] xor_mask;
  logic        busy;
  logic        change_irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, irq_cnt = 0;
  logic [15:0] model_last = 16'h0;

  gpio_mirror_ctrl_if bus ();

  gpio_mirror_ctrl #(.BASE_ADDR(BASE), .POLL_DIV(PDIV)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(aresetn),
    .axi          (bus.master),
    .enable       (enable),
    .xor_mask     (xor_mask),
    .busy         (busy),
    .change_irq   (change_irq)
  );

  always #5 clk = ~clk;

  // Handshake and pulse counters used to prove "exactly one" properties.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.m_axi_arvalid && bus.m_axi_arready) ar_cnt <= ar_cnt + 1;
    if (bus.m_axi_awvalid && bus.m_axi_awready) aw_cnt <= aw_cnt + 1;
    if (bus.m_axi_wvalid && bus.m_axi_wready)   w_cnt  <= w_cnt + 1;
    if (change_irq)                             irq_cnt <= irq_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: a good read with new low-half data produces one write.
  function automatic void ref_pred(input logic [31:0] rd, input logic [1:0] rr,
                                   input logic [15:0] mask,
                                   output logic wr, output logic [31:0] wd);
    wr = (rr == 2'b00) && (rd[15:0] != model_last);
    wd = {16'h0000, rd[15:0] ^ mask};
  endfunction

  task automatic ref_update(input logic [31:0] rd, input logic [1:0] rr);
    if (rr == 2'b00) model_last = rd[15:0];
  endtask

  task automatic wait_ar(output int n);
    n = 0;
    while (!bus.m_axi_arvalid && n < AR_LIM) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One full poll as seen by the slave; all actions on the falling edge.
  task automatic poll(input vec_t v, input bit drop_en, input bit rst_mid,
                      input string nm, output int t_ar);
    int n, a0, w0, r0, i0, mx;
    logic exp_irq;
    exp_irq = v.exp_wr & IRQ_ON;
    t_ar = 0;
    a0 = aw_cnt; w0 = w_cnt; r0 = ar_cnt; i0 = irq_cnt;
    xor_mask = v.mask;
    wait_ar(n);
    if (!bus.m_axi_arvalid) begin
      chk({nm, ".ar_timeout"}, 32'(n), 32'(AR_LIM + 1));
      return;
    end
    t_ar = cyc;
    for (int k = 0; k <= v.ar_dly; k++) begin
      chk({nm, ".arvalid"}, 32'({bus.m_axi_arvalid, bus.m_axi_awvalid}), 32'b10);
      chk({nm, ".araddr"}, bus.m_axi_araddr, BASE);
      bus.m_axi_arready = (k == v.ar_dly);
      @(negedge clk);
    end
    bus.m_axi_arready = 1'b0;
    chk({nm, ".rd_data_state"}, 32'({bus.m_axi_arvalid, bus.m_axi_rready, busy}), 32'b011);
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = v.rdata;
    bus.m_axi_rresp  = v.rresp;
    if (drop_en) enable = 1'b0;
    @(negedge clk);
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata  = $urandom;
    bus.m_axi_rresp  = 2'b00;
    chk({nm, ".irq"}, 32'(change_irq), 32'(exp_irq));
    chk({nm, ".rready_low"}, 32'(bus.m_axi_rready), 32'd0);
    if (v.exp_wr) begin
      chk({nm, ".wr_entry"}, 32'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}), 32'b110);
      chk({nm, ".awaddr"}, bus.m_axi_awaddr, BASE + 32'h4);
      chk({nm, ".wstrb"}, 32'(bus.m_axi_wstrb), 32'hF);
      if (rst_mid) begin
        aresetn = 1'b0;
        #1;
        chk({nm, ".rst_handshakes"},
            32'({bus.m_axi_arvalid, bus.m_axi_rready, bus.m_axi_awvalid, bus.m_axi_wvalid,
                 bus.m_axi_bready, busy, change_irq}), 32'd0);
        chk({nm, ".rst_wdata"}, bus.m_axi_wdata, 32'd0);
        chk({nm, ".rst_awaddr"}, bus.m_axi_awaddr, 32'd0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        wait_ar(n);
        chk({nm, ".rst_first_ar"}, 32'(n), 32'(PDIV));
        chk({nm, ".rst_no_write"}, 32'((aw_cnt - a0) + (w_cnt - w0)), 32'd0);
        chk({nm, ".rst_no_awvalid"}, 32'(bus.m_axi_awvalid), 32'd0);
        return;
      end
      mx = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
      for (int k = 0; k <= mx; k++) begin
        chk({nm, ".wr_valids"},
            32'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}),
            32'({(k <= v.aw_dly), (k <= v.w_dly), 1'b0}));
        chk({nm, ".wdata"}, bus.m_axi_wdata, v.exp_wd);
        bus.m_axi_awready = (k == v.aw_dly);
        bus.m_axi_wready  = (k == v.w_dly);
        if (k == 0) xor_mask = 16'($urandom);
        @(negedge clk);
      end
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      for (int k = 0; k <= v.b_dly; k++) begin
        chk({nm, ".wr_resp"},
            32'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}), 32'b001);
        bus.m_axi_bvalid = (k == v.b_dly);
        bus.m_axi_bresp  = 2'($urandom_range(0, 3));
        @(negedge clk);
      end
      bus.m_axi_bvalid = 1'b0;
      if (v.ar_dly == 0 && v.aw_dly == 0 && v.w_dly == 0 && v.b_dly == 0)
        chk({nm, ".tick_to_idle_le8"}, 32'((cyc - t_ar + 1) <= 8), 32'd1);
    end
    chk({nm, ".idle"},
        32'({busy, bus.m_axi_bready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}),
        32'd0);
    chk({nm, ".ar_count"}, 32'(ar_cnt - r0), 32'd1);
    chk({nm, ".aw_count"}, 32'(aw_cnt - a0), 32'(v.exp_wr));
    chk({nm, ".w_count"}, 32'(w_cnt - w0), 32'(v.exp_wr));
    chk({nm, ".irq_count"}, 32'(irq_cnt - i0), 32'(exp_irq));
  endtask

  vec_t vecs[8];
  vec_t zv;
  vec_t rv;

  initial begin
    int n, t1, t2, t3, hi;
    // rdata, rresp, mask, ar/aw/w/b delays, expected write, expected wdata
    vecs[0] = '{32'h0000_00A5, 2'b00, 16'h00FF, 0, 0, 0, 0, 1'b1, 32'h0000_005A};
    vecs[1] = '{32'hFFFF_00A5, 2'b00, 16'h0000, 0, 0, 0, 0, 1'b0, 32'h0};
    vecs[2] = '{32'h0000_1234, 2'b10, 16'h0000, 0, 0, 0, 0, 1'b0, 32'h0};
    vecs[3] = '{32'h0000_1234, 2'b00, 16'hF0F0, 0, 3, 0, 0, 1'b1, 32'h0000_E2C4};
    vecs[4] = '{32'h0000_8001, 2'b00, 16'h0000, 0, 0, 2, 2, 1'b1, 32'h0000_8001};
    vecs[5] = '{32'h0000_0000, 2'b01, 16'h0000, 1, 0, 0, 0, 1'b0, 32'h0};
    vecs[6] = '{32'h0000_0000, 2'b00, 16'hFFFF, 2, 1, 1, 0, 1'b1, 32'h0000_FFFF};
    vecs[7] = '{32'h0000_0000, 2'b11, 16'h0000, 0, 0, 0, 1, 1'b0, 32'h0};
    zv      = '{32'h0000_0000, 2'b00, 16'h0000, 0, 0, 0, 0, 1'b0, 32'h0};

    aresetn = 1'b0;
    enable  = 1'b1;
    xor_mask = 16'h0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bvalid = 1'b0;  bus.m_axi_bresp = 2'b00;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata = 32'h0;  bus.m_axi_rresp = 2'b00;
    repeat (3) @(negedge clk);

    chk("reset.handshakes",
        32'({bus.m_axi_arvalid, bus.m_axi_rready, bus.m_axi_awvalid, bus.m_axi_wvalid,
             bus.m_axi_bready, busy, change_irq}), 32'd0);
    chk("reset.araddr", bus.m_axi_araddr, 32'd0);
    chk("reset.awaddr", bus.m_axi_awaddr, 32'd0);
    chk("reset.wdata", bus.m_axi_wdata, 32'd0);
    chk("reset.wstrb", 32'(bus.m_axi_wstrb), 32'd0);

    aresetn = 1'b1;
    wait_ar(n);
    chk("first_tick_latency", 32'(n), 32'(PDIV));

    // Unchanged all-zero input: periodic reads, no writes, no pulses.
    poll(zv, 1'b0, 1'b0, "zero0", t1);
    poll(zv, 1'b0, 1'b0, "zero1", t2);
    poll(zv, 1'b0, 1'b0, "zero2", t3);
    chk("poll_period.a", 32'(t2 - t1), 32'(PDIV));
    chk("poll_period.b", 32'(t3 - t2), 32'(PDIV));

    for (int i = 0; i < 8; i++) begin
      poll(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i), t1);
      ref_update(vecs[i].rdata, vecs[i].rresp);
    end

    // Enable removed while read data is pending: finish, then stay quiet.
    rv = zv;
    rv.rdata = 32'h0000_0F0F;
    ref_pred(rv.rdata, rv.rresp, rv.mask, rv.exp_wr, rv.exp_wd);
    poll(rv, 1'b1, 1'b0, "en_drop", t1);
    ref_update(rv.rdata, rv.rresp);
    hi = 0;
    repeat (3 * PDIV) begin
      @(negedge clk);
      if (bus.m_axi_arvalid || busy) hi++;
    end
    chk("en_drop.no_new_read", 32'(hi), 32'd0);
    enable = 1'b1;

    // Reset asserted while the write is being requested.
    rv.rdata = 32'h0000_3C3C;
    ref_pred(rv.rdata, rv.rresp, rv.mask, rv.exp_wr, rv.exp_wd);
    poll(rv, 1'b0, 1'b1, "rst_mid", t1);
    model_last = 16'h0;
    poll(vecs[0], 1'b0, 1'b0, "after_rst", t1);
    ref_update(vecs[0].rdata, vecs[0].rresp);

    for (int i = 0; i < 40; i++) begin
      rv.rdata  = {16'($urandom), ($urandom_range(0, 2) == 0) ? model_last : 16'($urandom)};
      rv.rresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rv.mask   = 16'($urandom);
      rv.ar_dly = $urandom_range(0, 2);
      rv.aw_dly = $urandom_range(0, 3);
      rv.w_dly  = $urandom_range(0, 3);
      rv.b_dly  = $urandom_range(0, 2);
      ref_pred(rv.rdata, rv.rresp, rv.mask, rv.exp_wr, rv.exp_wd);
      poll(rv, 1'b0, 1'b0, $sformatf("rnd%0d", i), t1);
      ref_update(rv.rdata, rv.rresp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gpio_mirror_ctrl.md
GPIO_MIRROR_CTRL -- requirements
Module: gpio_mirror_ctrl

Interface
REQ-001 Parameters SHALL be: BASE_ADDR, 32'h0, GPIO block base address; POLL_DIV, 1000, clocks between poll ticks (>=2).
REQ-002 s_axi_aclk  in  1  clock; s_axi_aresetn  in  1  reset, asynchronous, active-low; all logic on rising edge of s_axi_aclk.
REQ-003 m_axi_awaddr out 32 write address; m_axi_awvalid out 1; m_axi_awready in 1.
REQ-004 m_axi_wdata out 32 write data; m_axi_wstrb out 4; m_axi_wvalid out 1; m_axi_wready in 1.
REQ-005 m_axi_bresp in 2 write response; m_axi_bvalid in 1; m_axi_bready out 1.
REQ-006 m_axi_araddr out 32 read address; m_axi_arvalid out 1; m_axi_arready in 1.
REQ-007 m_axi_rdata in 32 read data; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1.
REQ-008 enable  in  1  polling enable; xor_mask  in  16  output inversion mask; busy  out  1  transaction in flight; change_irq  out  1  input-change pulse.

Function
REQ-009 Free-running tick counter SHALL count 0..POLL_DIV-1 and wrap; tick asserted one cycle at POLL_DIV-1.
REQ-010 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; busy=1 in every state except IDLE.
REQ-011 IDLE->RD_ADDR on tick && enable; tick while busy or enable=0 SHALL be dropped, not queued.
REQ-012 RD_ADDR: araddr=BASE_ADDR+0x00, arvalid=1 held until arready sampled high, then RD_DATA with arvalid=0.
REQ-013 RD_DATA: rready=1; on rvalid: rresp!=2'b00 -> IDLE, no state update; else if rdata[15:0]!=last_in -> last_in<=rdata[15:0], change_irq pulse, WR_REQ; else IDLE.
REQ-014 WR_REQ: awaddr=BASE_ADDR+0x04, wdata={16'h0, last_in ^ xor_mask} (mask sampled on WR_REQ entry), wstrb=4'hF; awvalid and wvalid SHALL assert in same cycle.
REQ-015 awvalid and wvalid SHALL each deassert independently the cycle after own ready seen; WR_RESP entered once both accepted (same or different cycles).
REQ-016 WR_RESP: bready=1; on bvalid -> IDLE; bresp value ignored.
REQ-017 change_irq SHALL be exactly one cycle high per detected change, coincident with the rvalid acceptance cycle +1.
REQ-018 enable deasserted mid-transaction SHALL NOT abort; current transaction completes, then IDLE.
REQ-019 Latency tick->arvalid SHALL be 1 cycle; address/data/valid outputs SHALL be registered and stable while valid high.
REQ-020 Zero-wait slave: tick to return-to-IDLE with write SHALL not exceed 8 cycles.

Reset
REQ-021 On reset all valids, bready, rready, busy, change_irq SHALL be 0; addresses, wdata 0; wstrb 0; last_in 16'h0; counter 0; FSM IDLE.
REQ-022 Reset mid-transaction SHALL return to IDLE immediately with all handshake outputs low; no partial write completion attempted after release.

Configuration
REQ-023 Macro GPIO_MIRROR_IRQ_EN defined: change_irq driven per REQ-013/017; undefined: change_irq tied 0, all other behaviour identical.

Verification
REQ-024 Reset, POLL_DIV=4, enable=1, gpio_in=16'h0000 -> periodic reads of BASE+0x00, no AW/W, change_irq stays 0.
REQ-025 rdata=32'h0000_00A5, xor_mask=16'h00FF -> single write BASE+0x04 data 32'h0000_005A, wstrb F, one-cycle change_irq.
REQ-026 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3, bready only after both; single write.
REQ-027 rresp=2'b10 with rdata changed -> no write, no irq, last_in unchanged; next good read with same data triggers write.
REQ-028 enable dropped during RD_DATA -> transaction finishes, no further arvalid until enable=1 and next tick.
REQ-029 aresetn pulsed low in WR_REQ -> all valids 0 same cycle; after release first activity is a read at next tick; without GPIO_MIRROR_IRQ_EN rerun REQ-025 -> change_irq 0.
